// File: rtl/dt_key_loader.sv
// Bit-serial, parity-checked key loader for the locked decision-tree classifiers.
// The key shifts in LSB first and reaches KEY in one step, only after its parity check passes.
module dt_key_loader #(
    parameter int               KEY_W           = 32,
    parameter logic [KEY_W-1:0] DECOY_KEY       = '0,
    parameter int               TIMEOUT         = 64,
    parameter bit               LOCK_AFTER_LOAD = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             key_frame_start,
    input  logic             key_sdi,
    input  logic             key_sdi_valid,
    output logic [KEY_W-1:0] KEY,
    output logic             key_ready,
    output logic             key_err,
    output logic             key_busy,
    output logic             key_locked,
    output logic [2:0]       o_dbg_state
);

    // Handshake: key_sdi is accepted on each rising edge where key_sdi_valid is high,
    // unless key_frame_start is high on the same edge (the frame restarts instead).

    localparam int                CNT_W    = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(KEY_W - 1);
    localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT  = 3'd1,
        S_PAR    = 3'd2,
        S_COMMIT = 3'd3,
        S_LOCKED = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [KEY_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [7:0]       r_tmo;
    logic [KEY_W-1:0] r_key;
    logic             r_ready;
    logic             r_err;
    logic             r_locked;

    logic w_clear;
    logic w_shift_en;
    logic w_tmo_inc;
    logic w_set_err;
    logic w_commit;
    logic w_par_ok;

    // Even parity over the data bits plus the incoming parity bit.
    assign w_par_ok = ~(^{r_shadow, key_sdi});

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_clear    = 1'b0;
        w_shift_en = 1'b0;
        w_tmo_inc  = 1'b0;
        w_set_err  = 1'b0;
        w_commit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_frame_start) begin
                    w_clear = 1'b1;
                    w_next  = S_SHIFT;
                end
            end
            S_SHIFT, S_PAR: begin
                if (key_frame_start) begin
                    w_clear = 1'b1;
                    w_next  = S_SHIFT;
                end else if (key_sdi_valid) begin
                    if (r_state == S_SHIFT) begin
                        w_shift_en = 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_next = S_PAR;
                        end
                    end else if (w_par_ok) begin
                        w_next = S_COMMIT;
                    end else begin
                        w_set_err = 1'b1;
                        w_next    = S_IDLE;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_set_err = 1'b1;
                    w_next    = S_IDLE;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            S_COMMIT: begin
                w_commit = 1'b1;
                w_next   = LOCK_AFTER_LOAD ? S_LOCKED : S_IDLE;
            end
            S_LOCKED: begin
                w_next = S_LOCKED;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shadow  <= '0;
            r_bit_cnt <= '0;
            r_tmo     <= '0;
        end else if (w_clear) begin
            r_shadow  <= '0;
            r_bit_cnt <= '0;
            r_tmo     <= '0;
        end else if (w_shift_en) begin
            r_shadow[r_bit_cnt] <= key_sdi;
            r_bit_cnt           <= r_bit_cnt + CNT_W'(1);
            r_tmo               <= '0;
        end else if (w_tmo_inc) begin
            r_tmo <= r_tmo + 8'd1;
        end
    end

    // The shadow only reaches KEY on the commit edge; everything else holds it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_key    <= DECOY_KEY;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            if (w_commit) begin
                r_key    <= r_shadow;
                r_ready  <= 1'b1;
                r_locked <= LOCK_AFTER_LOAD;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end else if (w_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    assign KEY         = r_key;
    assign key_ready   = r_ready;
    assign key_err     = r_err;
    assign key_locked  = r_locked;
    assign key_busy    = (r_state == S_SHIFT) || (r_state == S_PAR);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dt_key_loader.sv
// Bench for dt_key_loader: one locking and one reloadable instance, directed frames,
// a frame-level reference model compared every cycle, plus literal checks at key points.
module tb_dt_key_loader;

    localparam int KW  = 32;
    localparam int TMO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       fs, vld, sdi;
    logic       sel;
    logic [1:0] fs_v, vld_v;

    assign fs_v  = {fs & sel, fs & ~sel};
    assign vld_v = {vld & sel, vld & ~sel};

    logic [1:0][KW-1:0] key_w;
    logic [1:0]         ready_w, err_w, busy_w, locked_w;
    logic [1:0][2:0]    dbg_w;

    dt_key_loader #(.KEY_W(KW), .DECOY_KEY(32'h0), .TIMEOUT(TMO), .LOCK_AFTER_LOAD(1'b1)) u_lock (
        .CLK(clk), .RST(rst_n), .key_frame_start(fs_v[0]), .key_sdi(sdi), .key_sdi_valid(vld_v[0]),
        .KEY(key_w[0]), .key_ready(ready_w[0]), .key_err(err_w[0]), .key_busy(busy_w[0]),
        .key_locked(locked_w[0]), .o_dbg_state(dbg_w[0])
    );

    dt_key_loader #(.KEY_W(KW), .DECOY_KEY(32'h0), .TIMEOUT(TMO), .LOCK_AFTER_LOAD(1'b0)) u_free (
        .CLK(clk), .RST(rst_n), .key_frame_start(fs_v[1]), .key_sdi(sdi), .key_sdi_valid(vld_v[1]),
        .KEY(key_w[1]), .key_ready(ready_w[1]), .key_err(err_w[1]), .key_busy(busy_w[1]),
        .key_locked(locked_w[1]), .o_dbg_state(dbg_w[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    // Frame-level model: collect bits, count idle gaps, commit one edge after a good parity bit.
    bit          lock_cfg [2] = '{1'b1, 1'b0};
    bit          m_in     [2];
    int          m_n      [2];
    int          m_gap    [2];
    logic [31:0] m_acc    [2];
    bit          m_pend   [2];
    logic [31:0] m_pval   [2];
    logic [31:0] m_key    [2];
    bit          m_ready  [2];
    bit          m_err    [2];
    bit          m_lockd  [2];

    task automatic model_step(input int d);
        if (!rst_n) begin
            m_in[d] = 0; m_n[d] = 0; m_gap[d] = 0; m_acc[d] = '0; m_pend[d] = 0;
            m_pval[d] = '0; m_key[d] = 32'h0; m_ready[d] = 0; m_err[d] = 0; m_lockd[d] = 0;
        end else if (m_lockd[d]) begin
            // locked: all inputs ignored
        end else if (m_pend[d]) begin
            m_key[d]   = m_pval[d];
            m_ready[d] = 1;
            m_lockd[d] = lock_cfg[d];
            m_pend[d]  = 0;
        end else if (fs_v[d]) begin
            m_in[d] = 1; m_n[d] = 0; m_gap[d] = 0; m_acc[d] = '0; m_err[d] = 0;
        end else if (m_in[d]) begin
            if (vld_v[d]) begin
                m_gap[d] = 0;
                if (m_n[d] < KW) begin
                    m_acc[d][m_n[d]] = sdi;
                    m_n[d]++;
                end else begin
                    m_in[d] = 0;
                    if ((($countones(m_acc[d]) + int'(sdi)) % 2) == 0) begin
                        m_pend[d] = 1;
                        m_pval[d] = m_acc[d];
                    end else begin
                        m_err[d] = 1;
                    end
                end
            end else begin
                m_gap[d]++;
                if (m_gap[d] == TMO) begin
                    m_err[d] = 1;
                    m_in[d]  = 0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) model_step(d);
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d_key", d), key_w[d], m_key[d]);
                check1($sformatf("d%0d_ready", d), ready_w[d], m_ready[d]);
                check1($sformatf("d%0d_err", d), err_w[d], m_err[d]);
                check1($sformatf("d%0d_busy", d), busy_w[d], m_in[d]);
                check1($sformatf("d%0d_locked", d), locked_w[d], m_lockd[d]);
            end
        end
    end

    bit watch_ready = 0;
    bit ready_dropped = 0;
    always @(negedge clk) begin
        if (watch_ready && !ready_w[1]) ready_dropped = 1;
    end

    task automatic drive(input logic f, input logic v, input logic b);
        @(negedge clk);
        fs = f; vld = v; sdi = b;
    endtask

    task automatic send_bits(input logic [31:0] w, input int lo, input int hi, input int gap);
        for (int i = lo; i <= hi; i++) begin
            drive(1'b0, 1'b1, w[i]);
            repeat (gap) drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic frame(input logic [31:0] w, input logic par, input int gap);
        drive(1'b1, 1'b0, 1'b0);
        send_bits(w, 0, KW - 1, gap);
        drive(1'b0, 1'b1, par);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] k_a, k_b, k_c;

    initial begin
        k_a = 32'hA74E7C1C;
        k_b = 32'h12345678;
        k_c = 32'h0000FFFF;
        fs = 0; vld = 0; sdi = 0; sel = 0; rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_key0", key_w[0], 32'h0);
        check("rst_key1", key_w[1], 32'h0);
        check1("rst_ready0", ready_w[0], 1'b0);
        check1("rst_err0", err_w[0], 1'b0);
        check1("rst_busy0", busy_w[0], 1'b0);
        check1("rst_locked0", locked_w[0], 1'b0);
        rst_n = 1;
        cmp_en = 1;

        // Parity error: 17 ones need parity 1, send 0.
        frame(k_a, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0);
        check1("par_err", err_w[0], 1'b1);
        check("par_state_idle", 32'(dbg_w[0]), 32'd0);
        check("par_key", key_w[0], 32'h0);
        check1("par_ready", ready_w[0], 1'b0);

        // Timeout: stall after bit 10; 63 idle edges are tolerated, the 64th trips.
        drive(1'b1, 1'b0, 1'b0);
        send_bits(k_a, 0, 10, 0);
        repeat (64) drive(1'b0, 1'b0, 1'b0);
        check1("tmo_63_err", err_w[0], 1'b0);
        check1("tmo_63_busy", busy_w[0], 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check1("tmo_64_err", err_w[0], 1'b1);
        check1("tmo_64_busy", busy_w[0], 1'b0);
        check("tmo_key", key_w[0], 32'h0);

        // Gapped load: 3 idle cycles between bits.
        frame(k_a, 1'b1, 3);
        drive(1'b0, 1'b0, 1'b0);
        check("gap_key_pre", key_w[0], 32'h0);
        drive(1'b0, 1'b0, 1'b0);
        check("gap_key", key_w[0], 32'hA74E7C1C);
        check1("gap_ready", ready_w[0], 1'b1);
        check1("gap_locked", locked_w[0], 1'b1);
        check1("gap_err", err_w[0], 1'b0);

        // Lock enforcement: a correct frame is ignored.
        frame(k_b, ^k_b, 0);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        check("lock_key", key_w[0], 32'hA74E7C1C);
        check1("lock_busy", busy_w[0], 1'b0);

        // Asynchronous reset between edges.
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("arst_key", key_w[0], 32'h0);
        check1("arst_locked", locked_w[0], 1'b0);
        check1("arst_ready", ready_w[0], 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Basic back-to-back load with latency check.
        drive(1'b1, 1'b0, 1'b0);
        send_bits(k_a, 0, 15, 0);
        drive(1'b0, 1'b1, k_a[16]);
        check("basic_mid_key", key_w[0], 32'h0);
        check1("basic_mid_busy", busy_w[0], 1'b1);
        send_bits(k_a, 17, KW - 1, 0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("basic_key_e1", key_w[0], 32'h0);
        drive(1'b0, 1'b0, 1'b0);
        check("basic_key_e2", key_w[0], 32'hA74E7C1C);
        check1("basic_locked", locked_w[0], 1'b1);

        // Reloadable instance: abort with start+valid collision at bit 20.
        sel = 1;
        drive(1'b1, 1'b0, 1'b0);
        send_bits(k_c, 0, 19, 0);
        drive(1'b1, 1'b1, 1'b1);
        send_bits(k_c, 0, KW - 1, 0);
        drive(1'b0, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        check("abort_key", key_w[1], 32'h0000FFFF);
        check1("abort_ready", ready_w[1], 1'b1);
        check1("abort_locked", locked_w[1], 1'b0);

        // Reload 1 then 2; ready must never drop.
        frame(32'h1, 1'b1, 0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        check("reload1_key", key_w[1], 32'h1);
        watch_ready = 1;
        frame(32'h2, 1'b1, 0);
        drive(1'b0, 1'b0, 1'b0);
        check("reload2_key_e1", key_w[1], 32'h1);
        drive(1'b0, 1'b0, 1'b0);
        check("reload2_key_e2", key_w[1], 32'h2);
        watch_ready = 0;
        check1("reload_ready_dropped", ready_dropped, 1'b0);

        // Failed reload keeps the old key.
        frame(32'h3, 1'b1, 0);
        drive(1'b0, 1'b0, 1'b0);
        check1("badreload_err", err_w[1], 1'b1);
        check("badreload_key", key_w[1], 32'h2);

        // Frame start during COMMIT is ignored.
        frame(32'h5, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("commit_fs_key", key_w[1], 32'h5);
        check1("commit_fs_busy", busy_w[1], 1'b0);
        check1("commit_fs_err", err_w[1], 1'b0);

        repeat (3) drive(1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
